// File: rtl/a2d_rr_sched.sv
// a2d_rr_sched: round-robin conversion scheduler for a shared 12-bit SPI A2D.
// Each nxt request runs one conversion of the current channel. A conversion is
// two SPI transactions: the first sends the channel and the second reads the result.
// Optional feature macro: A2D_TIMEOUT_EN adds a per-transaction watchdog that
// aborts a transaction whose done never arrives. This watchdog drives tmo_err.
module a2d_rr_sched #(
  parameter logic [2:0]  CH_LFT   = 3'd0,
  parameter logic [2:0]  CH_RGHT  = 3'd4,
  parameter logic [2:0]  CH_STEER = 3'd5,
  parameter logic [2:0]  CH_BATT  = 3'd6,
  parameter logic [15:0] TMO_CYC  = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        upd,
  output logic        busy,
  output logic        tmo_err
);

  typedef enum logic [1:0] {IDLE, CNV, GAP, RD} state_t;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic        upd_q, upd_d;
  logic        tmo_err_q, tmo_err_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] steer_q, steer_d;
  logic [11:0] batt_q, batt_d;
  logic        tmo_hit;

  // Map a round-robin slot to its A2D channel number
  function automatic logic [2:0] chnl_sel(input logic [1:0] ptr);
    case (ptr)
      2'd0:    chnl_sel = CH_LFT;
      2'd1:    chnl_sel = CH_RGHT;
      2'd2:    chnl_sel = CH_STEER;
      default: chnl_sel = CH_BATT;
    endcase
  endfunction

`ifdef A2D_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Watchdog: restarts on every wrt and counts the cycles spent waiting for done
  always_comb begin
    cnt_d = cnt_q;
    if (wrt_d)
      cnt_d = 16'd0;
    else if (state_q == CNV || state_q == RD)
      cnt_d = cnt_q + 16'd1;
  end

  // Watchdog register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 16'd0;
    else        cnt_q <= cnt_d;
  end

  assign tmo_hit = (cnt_q == TMO_CYC - 16'd1);
`else
  logic unused_tmo;
  assign unused_tmo = &{1'b0, TMO_CYC};
  assign tmo_hit    = 1'b0;
`endif

  // Next-state and registered-output logic of the conversion sequencer
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wrt_d     = 1'b0;
    cmd_d     = cmd_q;
    upd_d     = 1'b0;
    tmo_err_d = 1'b0;
    lft_d     = lft_q;
    rght_d    = rght_q;
    steer_d   = steer_q;
    batt_d    = batt_q;
    case (state_q)
      IDLE: begin
        if (nxt) begin
          wrt_d   = 1'b1;
          cmd_d   = {2'b00, chnl_sel(rr_ptr_q), 11'h000};
          state_d = CNV;
        end
      end
      CNV: begin
        if (done) begin
          state_d = GAP;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end
      end
      GAP: begin
        // The second transaction reuses the held command word
        wrt_d   = 1'b1;
        state_d = RD;
      end
      RD: begin
        if (done) begin
          case (rr_ptr_q)
            2'd0:    lft_d   = rd_data[11:0];
            2'd1:    rght_d  = rd_data[11:0];
            2'd2:    steer_d = rd_data[11:0];
            default: batt_d  = rd_data[11:0];
          endcase
          upd_d    = 1'b1;
          rr_ptr_d = rr_ptr_q + 2'd1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      wrt_q     <= 1'b0;
      cmd_q     <= 16'h0000;
      upd_q     <= 1'b0;
      tmo_err_q <= 1'b0;
      lft_q     <= 12'h000;
      rght_q    <= 12'h000;
      steer_q   <= 12'h000;
      batt_q    <= 12'h000;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      wrt_q     <= wrt_d;
      cmd_q     <= cmd_d;
      upd_q     <= upd_d;
      tmo_err_q <= tmo_err_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      steer_q   <= steer_d;
      batt_q    <= batt_d;
    end
  end

  logic unused_rd;
  assign unused_rd = &{1'b0, rd_data[15:12]};

  assign wrt       = wrt_q;
  assign cmd       = cmd_q;
  assign upd       = upd_q;
  assign tmo_err   = tmo_err_q;
  assign lft_ld    = lft_q;
  assign rght_ld   = rght_q;
  assign steer_pot = steer_q;
  assign batt      = batt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_rr_sched.sv
// tb_a2d_rr_sched: directed-vector bench for a2d_rr_sched with a hand-driven SPI master.
module tb_a2d_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nxt;
  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [15:0] rd_data;
  logic [11:0] lft_ld, rght_ld, steer_pot, batt;
  logic        upd, busy, tmo_err;

  int n_chk  = 0;
  int n_pass = 0;
  int upd_cnt = 0;
  int wrt_cnt = 0;
  int wrt_b2b = 0;
  logic wrt_prev = 1'b0;

  a2d_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld), .steer_pot(steer_pot),
    .batt(batt), .upd(upd), .busy(busy), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  // Pulse monitors
  always @(posedge clk) begin
    if (upd) upd_cnt <= upd_cnt + 1;
    if (wrt) wrt_cnt <= wrt_cnt + 1;
    if (wrt && wrt_prev) wrt_b2b <= wrt_b2b + 1;
    wrt_prev <= wrt;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full conversion; nxt stays high for hold extra cycles after acceptance
  task automatic do_conv(input logic [15:0] exp_cmd, input logic [15:0] rdat, input int hold);
    nxt = 1'b1;
    tick;
    chk("wrt_first", {15'd0, wrt}, 16'd1);
    chk("cmd_first", cmd, exp_cmd);
    chk("busy_cnv", {15'd0, busy}, 16'd1);
    repeat (hold) tick;
    nxt = 1'b0;
    tick;
    chk("wrt_cnv_low", {15'd0, wrt}, 16'd0);
    rd_data = 16'hDEAD;
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("wrt_gap_low", {15'd0, wrt}, 16'd0);
    tick;
    chk("wrt_second", {15'd0, wrt}, 16'd1);
    chk("cmd_second", cmd, exp_cmd);
    tick;
    rd_data = rdat;
    done = 1'b1;
    tick;
    done = 1'b0;
    chk("upd_pulse", {15'd0, upd}, 16'd1);
    chk("busy_after", {15'd0, busy}, 16'd0);
    tick;
    chk("upd_one_cycle", {15'd0, upd}, 16'd0);
  endtask

  task automatic chk_results(input logic [11:0] l, input logic [11:0] r,
                             input logic [11:0] s, input logic [11:0] b);
    chk("lft_ld", {4'd0, lft_ld}, {4'd0, l});
    chk("rght_ld", {4'd0, rght_ld}, {4'd0, r});
    chk("steer_pot", {4'd0, steer_pot}, {4'd0, s});
    chk("batt", {4'd0, batt}, {4'd0, b});
  endtask

  initial begin
    int u0, w0;
    bit seen;
    rst_n = 1'b0; nxt = 1'b0; done = 1'b0; rd_data = 16'h0000;
    repeat (3) tick;
    // Reset state
    chk_results(12'h000, 12'h000, 12'h000, 12'h000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_wrt", {15'd0, wrt}, 16'd0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_tmo", {15'd0, tmo_err}, 16'd0);
    chk("rst_upd", {15'd0, upd}, 16'd0);
    @(negedge clk) rst_n = 1'b1;
    tick;

    // First conversion, then the full round robin and the wrap
    do_conv(16'h0000, 16'h0ABC, 0);
    chk_results(12'hABC, 12'h000, 12'h000, 12'h000);
    do_conv(16'h2000, 16'hF123, 0);
    chk_results(12'hABC, 12'h123, 12'h000, 12'h000);
    do_conv(16'h2800, 16'h0456, 0);
    chk_results(12'hABC, 12'h123, 12'h456, 12'h000);
    do_conv(16'h3000, 16'h0789, 0);
    chk_results(12'hABC, 12'h123, 12'h456, 12'h789);
    do_conv(16'h0000, 16'h0111, 0);
    chk_results(12'h111, 12'h123, 12'h456, 12'h789);

    // nxt held for 10 cycles in CNV yields one conversion
    u0 = upd_cnt; w0 = wrt_cnt;
    do_conv(16'h2000, 16'h0222, 10);
    repeat (3) tick;
    chk("hold_upd_cnt", 16'(upd_cnt - u0), 16'd1);
    chk("hold_wrt_cnt", 16'(wrt_cnt - w0), 16'd2);
    chk_results(12'h111, 12'h222, 12'h456, 12'h789);

    // done while idle is ignored
    rd_data = 16'h0FFF; done = 1'b1;
    tick;
    done = 1'b0;
    chk("idle_done_busy", {15'd0, busy}, 16'd0);
    chk("idle_done_upd", {15'd0, upd}, 16'd0);
    chk_results(12'h111, 12'h222, 12'h456, 12'h789);

    // Reset during RD, then a late done
    nxt = 1'b1; tick; nxt = 1'b0;
    tick;
    done = 1'b1; tick; done = 1'b0;
    tick;
    chk("pre_rst_wrt", {15'd0, wrt}, 16'd1);
    tick;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_wrt", {15'd0, wrt}, 16'd0);
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_cmd", cmd, 16'h0000);
    chk_results(12'h000, 12'h000, 12'h000, 12'h000);
    @(negedge clk) rst_n = 1'b1;
    u0 = upd_cnt;
    rd_data = 16'h0FFF; done = 1'b1;
    tick;
    done = 1'b0;
    tick;
    chk("late_done_upd", 16'(upd_cnt - u0), 16'd0);
    chk("late_done_busy", {15'd0, busy}, 16'd0);
    chk("late_done_wrt", {15'd0, wrt}, 16'd0);
    chk_results(12'h000, 12'h000, 12'h000, 12'h000);

    // done never returned
    u0 = upd_cnt;
    nxt = 1'b1; tick; nxt = 1'b0;
    chk("tmo_cmd", cmd, 16'h0000);
`ifdef A2D_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      tick;
      if (tmo_err) seen = 1'b1;
    end
    chk("tmo_seen", {15'd0, seen}, 16'd1);
    tick;
    chk("tmo_one_cycle", {15'd0, tmo_err}, 16'd0);
    chk("tmo_busy", {15'd0, busy}, 16'd0);
    chk("tmo_no_upd", 16'(upd_cnt - u0), 16'd0);
    do_conv(16'h0000, 16'h0333, 0);
    chk_results(12'h333, 12'h000, 12'h000, 12'h000);
`else
    seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      tick;
      if (tmo_err) seen = 1'b1;
    end
    chk("no_tmo_busy", {15'd0, busy}, 16'd1);
    chk("no_tmo_err", {15'd0, seen}, 16'd0);
    chk("no_tmo_upd", 16'(upd_cnt - u0), 16'd0);
`endif
    chk("wrt_back_to_back", 16'(wrt_b2b), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
